dac_multi_ch: RTL and testbench
===============================

Name: dac_multi_ch

Overview:
- Parametrised multi-channel DAC core, successor to the single 12-bit DAC top.
- Holds CHANNELS sample registers loaded byte-wise over an 8-bit bus and drives one 1-bit modulated output per channel.
- Output mode is first-order sigma-delta or PWM.
- Shadow/active double buffering with a global LDAC strobe gives glitch-free, simultaneous channel updates.
- Sits behind the tt_um top: ui_in/uio_in feed the load bus, uo_out carries dac_out.

Parameters:
- WIDTH, 12, sample width in bits; legal range 9..16.
- CHANNELS, 4, number of output channels; legal range 1..8.
- CH_W, $clog2(CHANNELS) with minimum 1, channel-select width (localparam).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  modulator enable
- mode  in  1  0 = sigma-delta, 1 = PWM
- din  in  8  write data byte
- din_valid  in  1  write strobe, one byte per cycle
- byte_sel  in  1  0 = low byte to staging, 1 = high bits plus commit to shadow
- ch_sel  in  CH_W  target channel for a commit
- ldac  in  1  copy all shadow registers to active registers
- dac_out  out  CHANNELS  modulated 1-bit outputs, registered
- frame  out  1  one-cycle pulse at PWM/frame counter wrap

Behaviour:
- Reset (async assert, sync release): staging, shadow[], active[], acc[], cnt, mode_q = 0; dac_out = 0; frame = 0.
- Write, din_valid & !byte_sel: staging[7:0] <= din.
- Write, din_valid & byte_sel: shadow[ch_sel] <= {din[WIDTH-9:0], staging[7:0]}.
  - din bits above WIDTH-9 are ignored.
  - staging is not cleared, so a commit without a fresh low byte reuses the old staging value.
  - ch_sel >= CHANNELS: write dropped.
- ldac = 1: active[i] <= shadow[i] for all i, next cycle.
  - ldac in the same cycle as a commit: active takes the OLD shadow; the new value lands in shadow only.
- Frame counter cnt (WIDTH bits):
  - free-running while ena=1; wraps from 2^WIDTH-1 to 0.
  - frame=1 in the cycle after cnt == 2^WIDTH-1 (registered), in both modes.
- Sigma-delta mode (mode_q=0), per channel, acc is WIDTH+1 bits:
  - sum = {1'b0, acc[WIDTH-1:0]} + active[i]
  - acc <= sum; dac_out[i] <= sum[WIDTH].
  - Ones density over 2^WIDTH cycles equals active[i] exactly.
- PWM mode (mode_q=1): dac_out[i] <= (cnt < active[i]).
  - Code 0 gives constant 0.
  - Code 2^WIDTH-1 gives low for 1 cycle per period.
- Mode change: mode sampled into mode_q each cycle. When mode != mode_q, cnt and all acc clear to 0 in that cycle and dac_out is forced 0 for that cycle.
- ena = 0: cnt and acc frozen; dac_out forced 0 next cycle; frame = 0.
  - Writes and ldac still take effect.
- Latency: an active-register change is visible on dac_out 1 cycle after the next accumulator/counter step (2 cycles after the ldac cycle).
- Reset mid-operation: everything returns to reset values immediately (asynchronous); no partial writes survive.

Decomposition:
- Package dac_pkg:
  - MODE_SD = 1'b0, MODE_PWM = 1'b1
  - DAC_WIDTH_MIN = 9, DAC_WIDTH_MAX = 16, DAC_CH_MAX = 8
  - elaboration-time parameter range checks
- Sub-module dac_sd_channel, instantiated CHANNELS times via generate.
  - Ports: clk, rst_n, en, clr, mode, code[WIDTH-1:0], cnt[WIDTH-1:0], out.
  - Contains the accumulator and the output mux.
- Top owns staging, shadow/active banks, cnt, mode_q and frame.

Test Plan:
- Reset then idle: after rst_n release with ena=1, code 0 on all channels -> dac_out = 0 for 5000 cycles; frame pulses every 4096 cycles.
- Sigma-delta density (WIDTH=12): load ch0 = 0x800, ch1 = 0x001, ch2 = 0xFFF, ldac; count ones over 4096 cycles -> exactly 2048, 1 and 4095. ch0 also alternates 1,0.
- PWM (mode=1): ch3 = 0x100, ldac; within one frame -> dac_out[3] high for exactly 256 consecutive cycles starting at cnt = 0.
- Double buffering: commit ch0 = 0x123 without ldac -> output unchanged. Commit in the same cycle as ldac -> active keeps the old value; next ldac applies 0x123.
- Byte protocol edges: high-byte din = 0xF5 with WIDTH=12 -> only 0x5 used. ch_sel = 5 with CHANNELS=4 -> no register changes. Second commit without a new low byte reuses the staging value.
- Mode switch and ena: toggle mode mid-frame -> cnt and acc read 0 next cycle, dac_out 0 for that cycle. ena=0 -> dac_out = 0 and cnt frozen; ena=1 resumes from the frozen cnt.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the multi-channel DAC core: output modes,
// legal parameter ranges and the elaboration-time range check.
package dac_pkg;

  typedef enum logic {
    MODE_SD  = 1'b0,
    MODE_PWM = 1'b1
  } dac_mode_e;

  localparam int DAC_WIDTH_MIN = 9;
  localparam int DAC_WIDTH_MAX = 16;
  localparam int DAC_CH_MAX    = 8;

  // True when the sample width and channel count are within the supported range.
  function automatic bit dac_params_ok(input int width, input int channels);
    return (width >= DAC_WIDTH_MIN) && (width <= DAC_WIDTH_MAX) &&
           (channels >= 1) && (channels <= DAC_CH_MAX);
  endfunction

endpackage

// File: rtl/dac_sd_channel.sv
// One DAC output channel: first-order sigma-delta accumulator plus the
// PWM comparator, muxed onto a single registered output bit.
module dac_sd_channel
  import dac_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  dac_mode_e        mode,
  input  logic [WIDTH-1:0] code,
  input  logic [WIDTH-1:0] cnt,
  output logic             out
);

  // Only the low WIDTH bits of the accumulator carry state; the carry out
  // of the sum is the modulator bit and is not fed back.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_q, out_d;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, code};
  assign out = out_q;

  // Next accumulator and output bit; a clear or a disabled modulator forces the output low.
  always_comb begin
    acc_d = acc_q;
    out_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      if (mode == MODE_SD) begin
        acc_d = sum[WIDTH-1:0];
        out_d = sum[WIDTH];
      end else begin
        out_d = (cnt < code);
      end
    end
  end

  // Accumulator and registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/dac_multi_ch.sv
// Multi-channel DAC core: byte-wise load bus into staging/shadow registers,
// a global LDAC strobe copying shadow to active, a shared frame counter and
// one sigma-delta/PWM channel per output bit.
module dac_multi_ch
  import dac_pkg::*;
#(
  parameter  int WIDTH    = 12,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                mode,
  input  logic [7:0]          din,
  input  logic                din_valid,
  input  logic                byte_sel,
  input  logic [CH_W-1:0]     ch_sel,
  input  logic                ldac,
  output logic [CHANNELS-1:0] dac_out,
  output logic                frame
);

  if (!dac_params_ok(WIDTH, CHANNELS)) begin : gen_param_error
    $error("dac_multi_ch: WIDTH must be 9..16 and CHANNELS 1..8");
  end

  logic [7:0]       staging_q, staging_d;
  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] active_q [CHANNELS];
  logic [WIDTH-1:0] cnt_q, cnt_d;
  dac_mode_e        mode_q, mode_in;
  logic             frame_q, frame_d;
  logic             mode_change;
  logic             commit;
  logic [WIDTH-1:0] commit_val;

  assign mode_in    = dac_mode_e'(mode);
  assign mode_change = (mode_in != mode_q);
  assign commit     = din_valid & byte_sel;
  assign commit_val = {din[WIDTH-9:0], staging_q};
  assign frame      = frame_q;

  // Next staging byte, frame counter and frame pulse; a mode switch restarts the frame.
  always_comb begin
    staging_d = staging_q;
    cnt_d     = cnt_q;
    frame_d   = 1'b0;
    if (din_valid && !byte_sel) begin
      staging_d = din;
    end
    if (mode_change) begin
      cnt_d = '0;
    end else if (ena) begin
      cnt_d   = cnt_q + 1'b1;
      frame_d = (cnt_q == '1);
    end
  end

  // Control registers: staging byte, frame counter, sampled mode and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_SD;
      frame_q   <= 1'b0;
    end else begin
      staging_q <= staging_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_in;
      frame_q   <= frame_d;
    end
  end

  // Shadow/active banks; LDAC copies the pre-edge shadow so a same-cycle commit lands in shadow only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ldac) begin
          active_q[i] <= shadow_q[i];
        end
        if (commit && (ch_sel == CH_W'(i))) begin
          shadow_q[i] <= commit_val;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    dac_sd_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (ena),
      .clr  (mode_change),
      .mode (mode_q),
      .code (active_q[g]),
      .cnt  (cnt_q),
      .out  (dac_out[g])
    );
  end

endmodule

// File: tb/tb_dac_multi_ch.sv
// Self-checking bench for dac_multi_ch. Five channels are used so that
// channel selects beyond the last channel are representable on ch_sel.
module tb_dac_multi_ch;

  localparam int W    = 12;
  localparam int CH   = 5;
  localparam int CHW  = 3;
  localparam int FULL = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          mode;
  logic [7:0]    din;
  logic          din_valid;
  logic          byte_sel;
  logic [CHW-1:0] ch_sel;
  logic          ldac;
  logic [CH-1:0] dac_out;
  logic          frame;

  int vectors = 0;
  int miscompares = 0;

  int onesCnt [CH];
  int nSamples, firstHigh, runLen, toggles;
  bit gotFrame;

  // Reference model state (integer arithmetic on the behavioural rules).
  int unsigned mStage = 0;
  int unsigned mCnt = 0;
  int unsigned mShadow [CH];
  int unsigned mActive [CH];
  int unsigned mAcc [CH];
  int unsigned mSum;
  bit          mMode = 1'b0;
  bit          mChg;
  bit [CH-1:0] mOut = '0;
  bit          mFrame = 1'b0;

  always #5 clk = ~clk;

  dac_multi_ch #(
    .WIDTH   (W),
    .CHANNELS(CH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .mode     (mode),
    .din      (din),
    .din_valid(din_valid),
    .byte_sel (byte_sel),
    .ch_sel   (ch_sel),
    .ldac     (ldac),
    .dac_out  (dac_out),
    .frame    (frame)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle from a negedge; strobes drop again at the next negedge.
  task automatic applyStimulus(input bit v, input bit b, input int ch, input logic [7:0] d, input bit ld);
    din_valid = v;
    byte_sel  = b;
    ch_sel    = ch[CHW-1:0];
    din       = d;
    ldac      = ld;
    @(negedge clk);
    din_valid = 1'b0;
    byte_sel  = 1'b0;
    ldac      = 1'b0;
  endtask

  task automatic writeLow(input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 0, d, 1'b0);
  endtask

  task automatic commitHigh(input int ch, input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, ch, d, 1'b0);
  endtask

  task automatic strobeLdac();
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b1);
  endtask

  // Count ones per channel (and ch0 toggles) over n consecutive samples.
  task automatic countWindow(input int n);
    logic prev;
    prev = 1'b0;
    toggles = 0;
    for (int c = 0; c < CH; c++) onesCnt[c] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) onesCnt[c] += int'(dac_out[c]);
      if (k > 0 && dac_out[0] != prev) toggles++;
      prev = dac_out[0];
    end
  endtask

  // Sample until the next frame pulse (bounded), counting ones and ch3's first high run.
  task automatic measureFrame();
    for (int c = 0; c < CH; c++) onesCnt[c] = 0;
    nSamples  = 0;
    firstHigh = -1;
    runLen    = 0;
    gotFrame  = 1'b0;
    while (!gotFrame && nSamples < 5000) begin
      @(negedge clk);
      nSamples++;
      for (int c = 0; c < CH; c++) onesCnt[c] += int'(dac_out[c]);
      if (dac_out[3] === 1'b1) begin
        if (firstHigh < 0) firstHigh = nSamples;
        if (nSamples == firstHigh + runLen) runLen++;
      end
      if (frame === 1'b1) gotFrame = 1'b1;
    end
  endtask

  // Behavioural model: one step per clock from the inputs present at the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mStage = 0;
      mCnt   = 0;
      mMode  = 1'b0;
      mOut   = '0;
      mFrame = 1'b0;
      for (int i = 0; i < CH; i++) begin
        mShadow[i] = 0;
        mActive[i] = 0;
        mAcc[i]    = 0;
      end
    end else begin
      mChg = (mode != mMode);
      for (int i = 0; i < CH; i++) begin
        mSum = mAcc[i] + mActive[i];
        if (mChg || !ena)  mOut[i] = 1'b0;
        else if (!mMode)   mOut[i] = (mSum >= FULL);
        else               mOut[i] = (mCnt < mActive[i]);
        if (mChg)                mAcc[i] = 0;
        else if (ena && !mMode)  mAcc[i] = mSum % FULL;
      end
      mFrame = ena && !mChg && (mCnt == FULL - 1);
      if (mChg)     mCnt = 0;
      else if (ena) mCnt = (mCnt + 1) % FULL;
      if (ldac) for (int i = 0; i < CH; i++) mActive[i] = mShadow[i];
      if (din_valid && byte_sel && (ch_sel < CH))
        mShadow[ch_sel] = (din % (1 << (W - 8))) * 256 + mStage;
      if (din_valid && !byte_sel) mStage = din;
      mMode = mode;
    end
  end

  // Per-cycle comparison of the DUT against the model, 1 time unit after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checkOutput("cyc_dac_out", dac_out, mOut);
      checkOutput("cyc_frame", frame, mFrame);
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f1, f2, extra, totalOnes, bad;
    rst_n = 1'b0; ena = 1'b1; mode = 1'b0; din = 8'h00;
    din_valid = 1'b0; byte_sel = 1'b0; ch_sel = '0; ldac = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_dac_out", dac_out, 0);
    checkOutput("reset_frame", frame, 0);
    rst_n = 1'b1;

    // Idle with all codes zero: no output activity, frame every 4096 cycles.
    f1 = -1; f2 = -1; extra = 0; totalOnes = 0;
    for (int k = 1; k <= 9000; k++) begin
      @(negedge clk);
      totalOnes += $countones(dac_out);
      if (frame === 1'b1) begin
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
        else extra++;
      end
    end
    checkOutput("idle_ones", totalOnes, 0);
    checkOutput("idle_frame1", f1, 4096);
    checkOutput("idle_frame2", f2, 8192);
    checkOutput("idle_extra_frames", extra, 0);

    // Sigma-delta densities.
    writeLow(8'h00); commitHigh(0, 8'h08);
    writeLow(8'h01); commitHigh(1, 8'h00);
    writeLow(8'hFF); commitHigh(2, 8'h0F);
    strobeLdac();
    repeat (2) @(negedge clk);
    countWindow(FULL);
    checkOutput("sd_ch0_800", onesCnt[0], 2048);
    checkOutput("sd_ch1_001", onesCnt[1], 1);
    checkOutput("sd_ch2_fff", onesCnt[2], 4095);
    checkOutput("sd_ch3_000", onesCnt[3], 0);
    checkOutput("sd_ch0_toggles", toggles, 4095);

    // Double buffering: commit without LDAC leaves the output alone.
    writeLow(8'h23); commitHigh(0, 8'h01);
    repeat (2) @(negedge clk);
    countWindow(FULL);
    checkOutput("dbuf_no_ldac", onesCnt[0], 2048);
    writeLow(8'h56);
    applyStimulus(1'b1, 1'b1, 0, 8'h04, 1'b1);
    repeat (2) @(negedge clk);
    countWindow(FULL);
    checkOutput("dbuf_same_cycle_old", onesCnt[0], 291);
    strobeLdac();
    repeat (2) @(negedge clk);
    countWindow(FULL);
    checkOutput("dbuf_next_ldac", onesCnt[0], 1110);
    checkOutput("dbuf_ch1_kept", onesCnt[1], 1);

    // Byte protocol edges.
    writeLow(8'h34); commitHigh(1, 8'hF5);
    commitHigh(2, 8'h00);
    writeLow(8'h00); commitHigh(3, 8'h01);
    commitHigh(5, 8'h0F);
    commitHigh(7, 8'h0F);
    strobeLdac();
    repeat (3) @(negedge clk);

    // Switch to PWM mid-frame: forced low for one cycle, then a fresh frame.
    mode = 1'b1;
    @(negedge clk);
    checkOutput("mode_switch_zero", dac_out, 0);
    measureFrame();
    checkOutput("pwm_frame_seen", gotFrame, 1);
    checkOutput("pwm_frame_len", nSamples, 4096);
    checkOutput("pwm_ch0_456", onesCnt[0], 1110);
    checkOutput("pwm_ch1_hi_f5", onesCnt[1], 1332);
    checkOutput("pwm_ch2_reuse", onesCnt[2], 52);
    checkOutput("pwm_ch3_100", onesCnt[3], 256);
    checkOutput("pwm_ch4_bad_sel", onesCnt[4], 0);
    checkOutput("pwm_ch3_first", firstHigh, 1);
    checkOutput("pwm_ch3_run", runLen, 256);

    // Freeze with ena low; writes and LDAC still land.
    repeat (50) @(negedge clk);
    ena = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      case (k)
        2:       writeLow(8'h00);
        3:       commitHigh(4, 8'h02);
        5:       strobeLdac();
        default: applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b0);
      endcase
      if (dac_out !== '0 || frame !== 1'b0) bad++;
    end
    checkOutput("ena_low_outputs", bad, 0);
    ena = 1'b1;
    measureFrame();
    checkOutput("ena_resume_frame", gotFrame, 1);
    checkOutput("ena_resume_len", nSamples, 4046);
    checkOutput("ena_resume_ch3", onesCnt[3], 206);
    measureFrame();
    checkOutput("ena_full_len", nSamples, 4096);
    checkOutput("ena_ch4_write", onesCnt[4], 512);

    // Asynchronous reset mid-operation.
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_out", dac_out, 5'h1F);
    #2;
    rst_n = 1'b0;
    mode  = 1'b0;
    #1;
    checkOutput("async_reset_out", dac_out, 0);
    checkOutput("async_reset_frame", frame, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    strobeLdac();
    repeat (2) @(negedge clk);
    countWindow(300);
    totalOnes = 0;
    for (int c = 0; c < CH; c++) totalOnes += onesCnt[c];
    checkOutput("post_reset_cleared", totalOnes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
